// File: rtl/dense_argmax_pkg.sv
// Shared constants and types for the dense-layer argmax classifier stage.
package dense_argmax_pkg;
    localparam int N_CLASSES  = 24;
    localparam int SCORE_W    = 10;
    localparam int IDX_W      = $clog2(N_CLASSES);
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, SCAN, PUSH} state_t;

    typedef struct packed {
        logic        [IDX_W-1:0]   idx;
        logic signed [SCORE_W-1:0] score;
    } result_t;
endpackage

// File: rtl/dense_argmax_3_result_fifo.sv
// First-word fall-through FIFO of result_t; push and pop may coincide at any occupancy.
module result_fifo
    import dense_argmax_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  result_t din,
    output logic    full,
    input  logic    pop,
    output result_t dout,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    result_t     mem_q [DEPTH];
    result_t     mem_d [DEPTH];
    logic        do_pop, do_push;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal).
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/dense_argmax_3.sv
// Captures a 24-score vector, scans it one compare per cycle for the argmax,
// and queues {index, score} in a small FWFT result FIFO.
module dense_argmax_3
    import dense_argmax_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vld_in,
    input  logic signed [SCORE_W-1:0] data_in [N_CLASSES-1:0],
    output logic                      busy,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic        [IDX_W-1:0]   class_out,
    output logic signed [SCORE_W-1:0] score_out,
    output logic                      overrun
);
    state_t                    state_q, state_d;
    logic signed [SCORE_W-1:0] score_q [N_CLASSES-1:0];
    logic signed [SCORE_W-1:0] score_d [N_CLASSES-1:0];
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic        [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic        [IDX_W-1:0]   idx_q, idx_d;
    logic                      overrun_q, overrun_d;
    logic                      fifo_full, fifo_empty, pop_ok, push_ok;
    result_t                   fifo_din, fifo_dout;

    assign busy    = (state_q != IDLE);
    assign pop_ok  = out_rdy && !fifo_empty;
    // A pop on the same edge frees the slot, so a full FIFO need not stall.
    assign push_ok = !fifo_full || pop_ok;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        idx_d      = idx_q;
        overrun_d  = overrun_q | (vld_in && state_q != IDLE);
        case (state_q)
            IDLE: if (vld_in) begin
                score_d    = data_in;
                best_d     = data_in[0];
                best_idx_d = '0;
                idx_d      = IDX_W'(1);
                state_d    = SCAN;
            end
            SCAN: begin
                // Strict compare: ties keep the lower index.
                if (score_q[idx_q] > best_q) begin
                    best_d     = score_q[idx_q];
                    best_idx_d = idx_q;
                end
                if (idx_q == IDX_W'(N_CLASSES-1)) state_d = PUSH;
                else                              idx_d   = idx_q + IDX_W'(1);
            end
            PUSH:    if (push_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) score_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
            overrun_q  <= overrun_d;
        end
    end

    assign fifo_din = '{idx: best_idx_q, score: best_q};

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state_q == PUSH),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (out_rdy),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign out_vld   = !fifo_empty;
    assign class_out = fifo_dout.idx;
    assign score_out = fifo_dout.score;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_dense_argmax_3.sv
// Randomised and directed bench for dense_argmax_3 against a queue-based argmax model.
module tb_dense_argmax_3;
    import dense_argmax_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, vld_in = 1'b0, out_rdy = 1'b0;
    logic signed [SCORE_W-1:0] data_in [N_CLASSES-1:0];
    logic                      busy, out_vld, overrun;
    logic        [IDX_W-1:0]   class_out;
    logic signed [SCORE_W-1:0] score_out;

    int checks = 0, failures = 0;
    int vec [N_CLASSES];
    int exp_idx_q [$];
    int exp_score_q [$];

    always #5 clk = ~clk;

    dense_argmax_3 dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .data_in(data_in),
        .busy(busy), .out_vld(out_vld), .out_rdy(out_rdy),
        .class_out(class_out), .score_out(score_out), .overrun(overrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: find the maximum value, then the first index holding it.
    task automatic model_push();
        int mx = -100000;
        int first = -1;
        foreach (vec[i]) if (vec[i] > mx) mx = vec[i];
        foreach (vec[i]) if (first < 0 && vec[i] == mx) first = i;
        exp_idx_q.push_back(first);
        exp_score_q.push_back(mx);
    endtask

    task automatic make_vec(input int peak_idx, input int peak);
        foreach (vec[i]) vec[i] = int'($urandom_range(peak + 511)) - 512;
        vec[peak_idx] = peak;
    endtask

    task automatic send(input bit expect_it);
        @(posedge clk) #1;
        foreach (vec[i]) data_in[i] = SCORE_W'(vec[i]);
        vld_in = 1'b1;
        if (expect_it) model_push();
        @(posedge clk) #1;
        vld_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy || out_vld || exp_idx_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_idx_q.size(), 0);
        chk("drain_out_vld", int'(out_vld), 0);
    endtask

    // Every accepted output is matched against the head of the model queue.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            int e_i = -1;
            int e_s = 9999;
            if (exp_idx_q.size() > 0) begin
                e_i = exp_idx_q.pop_front();
                e_s = exp_score_q.pop_front();
            end
            chk("out_class", int'(class_out), e_i);
            chk("out_score", int'(score_out), e_s);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, first_vld;
        foreach (data_in[i]) data_in[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_class", int'(class_out), 0);
        chk("rst_score", int'(score_out), 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        out_rdy = 1'b1;

        // Distinct maximum: latency and busy width
        foreach (vec[i]) vec[i] = 0;
        vec[17] = 37;
        send(1);
        busy_cnt = 0;
        first_vld = -1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (out_vld && first_vld < 0) first_vld = k;
        end
        chk("latency", first_vld, 24);
        chk("busy_cycles", busy_cnt, 24);
        chk("no_overrun", int'(overrun), 0);
        drain(60);

        // Ties and extremes
        foreach (vec[i]) vec[i] = -512;
        vec[5] = -3;
        vec[20] = -3;
        send(1);
        drain(60);
        foreach (vec[i]) vec[i] = 511;
        send(1);
        drain(60);

        // Backpressure: third vector parks in PUSH
        @(posedge clk) #1 out_rdy = 1'b0;
        make_vec(2, 300);   send(1); repeat (128) @(posedge clk);
        make_vec(9, -100);  send(1); repeat (128) @(posedge clk);
        make_vec(23, 511);  send(1); repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_busy_hold", int'(busy), 1);
        chk("bp_out_vld", int'(out_vld), 1);
        @(posedge clk) #1 out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_busy_drop", int'(busy), 0);
        chk("bp_still_vld", int'(out_vld), 1);
        drain(40);

        // Push and pop on the same edge while full
        @(posedge clk) #1 out_rdy = 1'b0;
        make_vec(4, 200);  send(1); repeat (30) @(posedge clk);
        make_vec(11, 10);  send(1); repeat (30) @(posedge clk);
        make_vec(0, -5);   send(1);
        repeat (23) @(posedge clk);
        #1 out_rdy = 1'b1;
        @(posedge clk) #1 out_rdy = 1'b0;
        @(negedge clk);
        chk("pp_full_no_stall", int'(busy), 0);
        chk("pp_full_vld", int'(out_vld), 1);
        @(posedge clk) #1 out_rdy = 1'b1;
        drain(40);

        // Overrun
        make_vec(7, 100);  send(1);
        repeat (8) @(posedge clk);
        make_vec(15, 400); send(0);
        @(negedge clk);
        chk("ovr_set", int'(overrun), 1);
        drain(60);
        chk("ovr_sticky", int'(overrun), 1);
        repeat (40) @(posedge clk);
        make_vec(19, 250); send(1);
        drain(60);
        chk("ovr_sticky2", int'(overrun), 1);

        // Asynchronous reset mid-scan with one entry queued
        @(posedge clk) #1 out_rdy = 1'b0;
        make_vec(3, 50);  send(1); repeat (30) @(posedge clk);
        make_vec(6, 60);  send(1);
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", int'(out_vld), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        exp_idx_q.delete();
        exp_score_q.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        out_rdy = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_no_stale", int'(out_vld), 0);
        make_vec(22, 77); send(1);
        drain(60);

        // Random vectors, including natural ties
        for (int r = 0; r < 10; r++) begin
            foreach (vec[i]) vec[i] = int'($urandom_range(1023)) - 512;
            if (r % 3 == 0) vec[$urandom_range(N_CLASSES-1)] = vec[$urandom_range(N_CLASSES-1)];
            send(1);
            repeat (28 + $urandom_range(8)) @(posedge clk);
        end
        drain(80);
        chk("final_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
